// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: 8 blocks x 16 bytes, zero-cycle hits, single
// outstanding block fill from instruction memory on a miss.
module instruction_cache (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [9:0]   address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readinst,
    input  logic         mem_busywait,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    valid_q, valid_d;
    logic [5:0]    miss_q, miss_d;
    logic          mem_read_q, mem_read_d;
    logic          seen_q, seen_d;
    logic [2:0]    tag_q  [8];
    logic [127:0]  data_q [8];

    logic [2:0]    idx;
    logic [1:0]    word_sel;
    logic          hit;
    logic          fill_en;

    assign idx      = address[6:4];
    assign word_sel = address[3:2];
    assign hit      = read && valid_q[idx] && (tag_q[idx] == address[9:7]);

    assign instruction = hit ? data_q[idx][32*word_sel +: 32] : 32'h0;
    assign busywait    = (state_q != IDLE) || (read && !hit);
    assign mem_read    = mem_read_q;
    assign mem_address = miss_q;
    assign state_dbg   = state_q;
    assign fill_en     = (state_q == UPDATE);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        miss_d     = miss_q;
        mem_read_d = mem_read_q;
        seen_d     = seen_q;
        case (state_q)
            IDLE: begin
                if (read && !hit) begin
                    state_d    = MEM_READ;
                    miss_d     = address[9:4];
                    mem_read_d = 1'b1;
                    seen_d     = 1'b0;
                end
            end
            MEM_READ: begin
                // seen_q ensures memory has sampled mem_read before its busy is trusted
                seen_d = 1'b1;
                if (seen_q && !mem_busywait) begin
                    state_d    = UPDATE;
                    mem_read_d = 1'b0;
                end
            end
            UPDATE: begin
                valid_d[miss_q[2:0]] = 1'b1;
                state_d              = IDLE;
            end
            default: begin
                state_d    = IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= 8'h0;
            miss_q     <= 6'h0;
            mem_read_q <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            miss_q     <= miss_d;
            mem_read_q <= mem_read_d;
            seen_q     <= seen_d;
        end
    end

    // Tag/data arrays are not reset; the reset term only blocks a fill that reset interrupts.
    always_ff @(posedge clock) begin
        if (fill_en && !reset) begin
            data_q[miss_q[2:0]] <= mem_readinst;
            tag_q[miss_q[2:0]]  <= miss_q[5:3];
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: behavioural instruction memory, a vector table
// of accesses, and hand-written sequences for mid-fill address change and reset.
module tb_instruction_cache;

    localparam int MEM_LAT = 3;

    logic         clock;
    logic         reset;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;
    logic [1:0]   state_dbg;

    int n_checks;
    int n_fail;
    int mem_cnt;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [9:0]  addr;
        logic        rd;
        logic        miss;
        logic [5:0]  madr;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[16];

    instruction_cache dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait),
        .state_dbg    (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] w);
        return {8'hA5, 2'b00, blk, 8'h5A, 6'h00, w};
    endfunction

    // Instruction memory: busy from the first cycle of a request for MEM_LAT edges.
    always @(posedge clock or posedge reset) begin
        if (reset)         mem_cnt <= 0;
        else if (mem_read) mem_cnt <= mem_cnt + 1;
        else               mem_cnt <= 0;
    end
    assign mem_busywait = mem_read && (mem_cnt < MEM_LAT);
    assign mem_readinst = {mem_word(mem_address, 2'd3), mem_word(mem_address, 2'd2),
                           mem_word(mem_address, 2'd1), mem_word(mem_address, 2'd0)};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] a, input logic r, input logic m,
                                input logic [5:0] ma, input logic [31:0] ins);
        vec_t v;
        v.addr = a; v.rd = r; v.miss = m; v.madr = ma; v.instr = ins;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int id);
        int cyc;
        logic saw_mr;
        logic [5:0] madr_seen;
        @(negedge clock);
        read    = v.rd;
        address = v.addr;
        exp_q.push_back(v.instr);
        #1;
        check($sformatf("v%0d busy_start", id), {31'b0, busywait}, {31'b0, v.miss});
        cyc = 0; saw_mr = 1'b0; madr_seen = 6'h0;
        while (busywait && cyc < 50) begin
            @(negedge clock); #1;
            cyc++;
            if (mem_read && !saw_mr) begin
                saw_mr    = 1'b1;
                madr_seen = mem_address;
            end
        end
        if (v.miss) begin
            check($sformatf("v%0d penalty", id), cyc, MEM_LAT + 3);
            check($sformatf("v%0d mem_addr", id), {26'b0, madr_seen}, {26'b0, v.madr});
        end else begin
            check($sformatf("v%0d no_mem_read", id), {30'b0, saw_mr, mem_read}, 32'h0);
        end
        check($sformatf("v%0d instr", id), instruction, exp_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clock);
        read  = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        read     = 1'b1;
        address  = 10'h000;

        vecs[0]  = mk(10'h000, 1, 1, 6'h00, mem_word(6'h00, 0));
        vecs[1]  = mk(10'h004, 1, 0, 6'h00, mem_word(6'h00, 1));
        vecs[2]  = mk(10'h008, 1, 0, 6'h00, mem_word(6'h00, 2));
        vecs[3]  = mk(10'h00C, 1, 0, 6'h00, mem_word(6'h00, 3));
        vecs[4]  = mk(10'h003, 1, 0, 6'h00, mem_word(6'h00, 0));
        vecs[5]  = mk(10'h080, 1, 1, 6'h08, mem_word(6'h08, 0));
        vecs[6]  = mk(10'h000, 1, 1, 6'h00, mem_word(6'h00, 0));
        vecs[7]  = mk(10'h084, 1, 1, 6'h08, mem_word(6'h08, 1));
        vecs[8]  = mk(10'h01C, 1, 1, 6'h01, mem_word(6'h01, 3));
        vecs[9]  = mk(10'h088, 0, 0, 6'h00, 32'h0);
        vecs[10] = mk(10'h014, 1, 0, 6'h00, mem_word(6'h01, 1));
        vecs[11] = mk(10'h3FC, 1, 1, 6'h3F, mem_word(6'h3F, 3));
        vecs[12] = mk(10'h3F8, 1, 0, 6'h00, mem_word(6'h3F, 2));
        vecs[13] = mk(10'h08F, 1, 0, 6'h00, mem_word(6'h08, 3));
        vecs[14] = mk(10'h01E, 1, 0, 6'h00, mem_word(6'h01, 3));
        vecs[15] = mk(10'h3A5, 0, 0, 6'h00, 32'h0);

        // Reset state: nothing valid, so a request stalls and no memory traffic.
        @(negedge clock); @(negedge clock); #1;
        check("rst busy_read1", {31'b0, busywait}, 32'h1);
        check("rst mem_read", {31'b0, mem_read}, 32'h0);
        check("rst mem_address", {26'b0, mem_address}, 32'h0);
        check("rst state", {30'b0, state_dbg}, 32'h0);
        read = 1'b0; #1;
        check("rst busy_read0", {31'b0, busywait}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) apply(vecs[i], i);
        #1;
        check("read0 state", {30'b0, state_dbg}, 32'h0);

        // Address changes while the fill for 0x010 is in flight.
        do_reset();
        @(negedge clock);
        read = 1'b1; address = 10'h010; #1;
        check("chg busy", {31'b0, busywait}, 32'h1);
        @(negedge clock); #1;
        check("chg mem_read", {31'b0, mem_read}, 32'h1);
        check("chg mem_addr1", {26'b0, mem_address}, 32'h01);
        address = 10'h020;
        cyc = 0;
        while (state_dbg != 2'd0 && cyc < 50) begin
            @(negedge clock); #1; cyc++;
        end
        check("chg fill_done", {31'b0, (cyc < 50)}, 32'h1);
        check("chg new_miss", {31'b0, busywait}, 32'h1);
        @(negedge clock); #1;
        check("chg mem_addr2", {26'b0, mem_address}, 32'h02);
        exp_q.push_back(mem_word(6'h02, 0));
        cyc = 0;
        while (busywait && cyc < 50) begin
            @(negedge clock); #1; cyc++;
        end
        check("chg instr2", instruction, exp_q.pop_front());
        apply(mk(10'h010, 1, 0, 6'h00, mem_word(6'h01, 0)), 100);

        // Reset lands during MEM_READ for 0x030.
        do_reset();
        apply(mk(10'h000, 1, 1, 6'h00, mem_word(6'h00, 0)), 200);
        @(negedge clock);
        read = 1'b1; address = 10'h030;
        @(negedge clock); #1;
        check("rmf in_mem_read", {31'b0, mem_read}, 32'h1);
        reset = 1'b1; #1;
        check("rmf mem_read_drop", {31'b0, mem_read}, 32'h0);
        check("rmf state", {30'b0, state_dbg}, 32'h0);
        check("rmf busy", {31'b0, busywait}, 32'h1);
        read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        apply(mk(10'h030, 1, 1, 6'h03, mem_word(6'h03, 0)), 201);
        apply(mk(10'h000, 1, 1, 6'h00, mem_word(6'h00, 0)), 202);

        check("sb empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 direct-mapped blocks of 16 bytes (4 x 32-bit words each).
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 read  input  1  CPU instruction-fetch request.
REQ-005 address  input  10  CPU byte address (PC): [9:7] tag, [6:4] index, [3:2] word offset, [1:0] ignored.
REQ-006 instruction  output  32  fetched instruction word.
REQ-007 busywait  output  1  CPU stall; high while the request is not served.
REQ-008 mem_read  output  1  block-read request to instruction memory.
REQ-009 mem_address  output  6  memory block address {tag,index}.
REQ-010 mem_readinst  input  128  memory block data; byte n of block at bits [8n+7:8n].
REQ-011 mem_busywait  input  1  memory busy; high from mem_read assertion until block data is valid.

Function
REQ-012 Per-block storage SHALL be: valid (1 bit), tag (3 bits), data (128 bits).
REQ-013 hit SHALL be read AND valid[index] AND (tag[index] == address[9:7]), evaluated combinationally from the live address.
REQ-014 instruction SHALL be data[index] bits [32*w+31:32*w], w = address[3:2], driven combinationally; 32'h0 when hit is low.
REQ-015 FSM states SHALL be IDLE, MEM_READ, UPDATE.
REQ-016 IDLE: read=0 -> busywait=0, stay; read=1 and hit -> busywait=0, stay (zero-cycle hit); read=1 and miss -> busywait=1, capture address[9:4] into a miss register, go MEM_READ next edge.
REQ-017 MEM_READ: mem_read=1, mem_address=miss register, busywait=1; go UPDATE on the first rising edge at which mem_busywait=0 and mem_read has been high for at least one prior edge.
REQ-018 UPDATE: mem_read=0, busywait=1; on the edge write mem_readinst into data[miss index], set tag=miss tag, valid=1; go IDLE.
REQ-019 After UPDATE the re-presented address SHALL hit in IDLE in the same cycle, busywait falling combinationally.
REQ-020 Miss penalty SHALL be: 1 cycle (IDLE->MEM_READ) + memory latency + 1 cycle (UPDATE).
REQ-021 mem_read SHALL be high only in MEM_READ; mem_address SHALL hold its last value outside MEM_READ.
REQ-022 A fill once started SHALL complete even if read falls or address changes; the fill uses the captured miss address only.
REQ-023 A miss to a valid block with a different tag SHALL overwrite it (no write-back; instruction cache is read-only).
REQ-024 The block SHALL issue at most one outstanding memory request.
REQ-025 Addresses differing only in [1:0] SHALL be treated identically.

Reset
REQ-026 While reset=1: state=IDLE, all valid bits=0, mem_read=0, mem_address=6'h0, miss register=0; busywait follows REQ-016 (high if read=1, since nothing hits).
REQ-027 Reset asserted mid-fill (MEM_READ or UPDATE) SHALL abort immediately: mem_read drops asynchronously, no tag/data/valid write occurs.
REQ-028 Data and tag arrays need not be cleared by reset.

Verification
REQ-029 Cold miss: reset, read=1, address=10'h000, memory returns block 0 -> mem_read=1 with mem_address=6'h00, after fill busywait=0 and instruction=block bits[31:0].
REQ-030 Spatial hit: following fill, address=10'h004, 10'h008, 10'h00C -> busywait stays 0, instruction=words 1,2,3 of block 0 each cycle, mem_read stays 0.
REQ-031 Conflict miss: address=10'h080 (tag 1, index 0) after block 0 filled -> miss, mem_address=6'h08, block replaced; then 10'h000 misses again with mem_address=6'h00.
REQ-032 Address change mid-fill: miss on 10'h010, change address to 10'h020 during MEM_READ -> fill still writes index 1 with mem_address=6'h01; 10'h020 then misses with mem_address=6'h02.
REQ-033 Reset mid-fill: assert reset during MEM_READ for 10'h030 -> mem_read=0 immediately, state IDLE, subsequent 10'h030 and 10'h000 both miss.
REQ-034 read=0 with any address -> busywait=0, mem_read=0, instruction=32'h0, no state change.
